// File: rtl/parity_frame_rx_if.sv
// Serial frame receiver bus: line side (bit_in/bit_valid) plus decoded result and status.
// master drives the serial line, slave is the receiver.
interface parity_frame_rx_if #(
  parameter int DATA_W = 3,
  parameter int CNT_W  = 8
);
  logic              bit_in;
  logic              bit_valid;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output bit_in, bit_valid,
    input  data_out, data_valid, parity_err, frame_err, busy, err_count
  );

  modport slave (
    input  bit_in, bit_valid,
    output data_out, data_valid, parity_err, frame_err, busy, err_count
  );
endinterface

// File: rtl/parity_frame_rx.sv
// Framed serial receiver for the parity generator output: start, DATA_W data bits
// (MSB first), parity, stop. Flags parity/framing errors and counts bad frames.
//
// state  | meaning
// IDLE   | waiting for a start bit (0) on a beat
// DATA   | shifting in DATA_W data bits, accumulating parity
// PARITY | folding the received parity bit into the running parity
// STOP   | sampling the stop bit, publishing the result
module parity_frame_rx #(
  parameter int DATA_W     = 3,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input logic              clk,
  input logic              rst,
  parity_frame_rx_if.slave rx
);
  localparam int CW = $clog2(DATA_W + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
  localparam logic          ODD      = (ODD_PARITY != 0);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg;
  logic              par;
  logic              perr_now;
  logic              ferr_now;

  // par already includes the received parity bit once in STOP
  assign perr_now = par ^ ODD;
  assign ferr_now = ~rx.bit_in;
  assign rx.busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      shreg         <= '0;
      par           <= 1'b0;
      rx.data_out   <= '0;
      rx.data_valid <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.err_count  <= '0;
    end else begin
      rx.data_valid <= 1'b0;
      if (rx.bit_valid) begin
        case (state)
          IDLE: begin
            if (!rx.bit_in) begin
              shreg <= '0;
              par   <= 1'b0;
              cnt   <= '0;
              state <= DATA;
            end
          end
          DATA: begin
            shreg <= DATA_W'({shreg, rx.bit_in});
            par   <= par ^ rx.bit_in;
            if (cnt == LAST_BIT) begin
              state <= PARITY;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          PARITY: begin
            par   <= par ^ rx.bit_in;
            state <= STOP;
          end
          STOP: begin
            rx.data_out   <= shreg;
            rx.parity_err <= perr_now;
            rx.frame_err  <= ferr_now;
            rx.data_valid <= 1'b1;
            if ((perr_now || ferr_now) && (rx.err_count != {CNT_W{1'b1}})) begin
              rx.err_count <= rx.err_count + CNT_W'(1);
            end
            // a 0 stop bit is never reused as the next start bit
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
